// File: rtl/lcd_ram_write_arbiter.sv
// Round-robin A/B arbiter for the LCD RAM write port: request sampled at edge N is written and acked in cycle N+1; requests wait while busy.
// Define LCD_ARB_CLEAR_EN to include the FILL_CHAR clear sequencer; without it busy/clear_done stay low.
module lcd_ram_write_arbiter #(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d
);

  logic              r_we, r_a_ack, r_b_ack, r_busy, r_done, r_last_b;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_d;

  logic              w_we, w_a_ack, w_b_ack, w_busy, w_done, w_last_b_nxt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_d;
  logic              w_a_elig, w_b_elig, w_pick_a, w_pick_b;

  // A requester whose ack is showing this cycle has not yet seen it, so it is not re-granted.
  assign w_a_elig = a_req & ~r_a_ack;
  assign w_b_elig = b_req & ~r_b_ack;
  assign w_pick_a = w_a_elig & (~w_b_elig | r_last_b);
  assign w_pick_b = w_b_elig & ~w_pick_a;

`ifdef LCD_ARB_CLEAR_EN
  typedef enum logic {ST_ARB, ST_CLEAR} state_t;
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ARB;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clear_start, FILL_CHAR};
`endif

  always_comb begin
    w_we         = w_pick_a | w_pick_b;
    w_addr       = r_addr;
    w_d          = r_d;
    w_a_ack      = w_pick_a;
    w_b_ack      = w_pick_b;
    w_last_b_nxt = w_pick_b | (r_last_b & ~w_pick_a);
    w_busy       = 1'b0;
    w_done       = 1'b0;
    if (w_pick_a) begin
      w_addr = a_addr;
      w_d    = a_data;
    end else if (w_pick_b) begin
      w_addr = b_addr;
      w_d    = b_data;
    end
`ifdef LCD_ARB_CLEAR_EN
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ARB: begin
        // r_busy is still high in the final clear cycle, which blocks a restart there.
        if (clear_start && !r_busy) begin
          w_state_nxt  = ST_CLEAR;
          w_cnt_nxt    = ADDR_W'(1);
          w_we         = 1'b1;
          w_addr       = '0;
          w_d          = FILL_CHAR;
          w_a_ack      = 1'b0;
          w_b_ack      = 1'b0;
          w_last_b_nxt = r_last_b;
          w_busy       = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_cnt_nxt    = r_cnt + ADDR_W'(1);
        w_we         = 1'b1;
        w_addr       = r_cnt;
        w_d          = FILL_CHAR;
        w_a_ack      = 1'b0;
        w_b_ack      = 1'b0;
        w_last_b_nxt = r_last_b;
        w_busy       = 1'b1;
        if (&r_cnt) begin
          w_done      = 1'b1;
          w_state_nxt = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_d      <= '0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_last_b <= 1'b1;
    end else begin
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_d      <= w_d;
      r_a_ack  <= w_a_ack;
      r_b_ack  <= w_b_ack;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_last_b <= w_last_b_nxt;
    end
  end

  assign ram_we     = r_we;
  assign ram_addr   = r_addr;
  assign ram_d      = r_d;
  assign a_ack      = r_a_ack;
  assign b_ack      = r_b_ack;
  assign busy       = r_busy;
  assign clear_done = r_done;

endmodule

// File: tb/tb_lcd_ram_write_arbiter.sv
// Bench for lcd_ram_write_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_lcd_ram_write_arbiter;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, b_req, clear_start;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ack, b_ack, busy, clear_done, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;

  always #5 clk = ~clk;

  lcd_ram_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected registered outputs for the current cycle.
  logic          e_we, e_aack, e_back, e_busy, e_done;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_d;
  bit            m_last_a;
  int            clr_q[$];

  function automatic void model_reset();
    e_we = 0; e_aack = 0; e_back = 0; e_busy = 0; e_done = 0;
    e_addr = '0; e_d = '0;
    m_last_a = 0;
    clr_q.delete();
  endfunction

  function automatic void model_step();
    bit ea, eb, ga, gb;
    int adr;
    ea = a_req && !e_aack;
    eb = b_req && !e_back;
    e_aack = 0; e_back = 0; e_done = 0; e_we = 0;
`ifdef LCD_ARB_CLEAR_EN
    if (clear_start && !e_busy)
      for (int i = 0; i < DEPTH; i++) clr_q.push_back(i);
    if (clr_q.size() > 0) begin
      adr    = clr_q.pop_front();
      e_we   = 1;
      e_addr = adr[AW-1:0];
      e_d    = 8'h20;
      e_busy = 1;
      e_done = (clr_q.size() == 0);
      return;
    end
`endif
    e_busy = 0;
    ga = ea && (!eb || !m_last_a);
    gb = eb && !ga;
    if (ga) begin
      e_we = 1; e_aack = 1; e_addr = a_addr; e_d = a_data; m_last_a = 1;
    end else if (gb) begin
      e_we = 1; e_back = 1; e_addr = b_addr; e_d = b_data; m_last_a = 0;
    end
  endfunction

  function automatic logic [31:0] dut_vec();
    return {13'd0, ram_we, ram_addr, ram_d, a_ack, b_ack, busy, clear_done};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {13'd0, e_we, e_addr, e_d, e_aack, e_back, e_busy, e_done};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cyc", dut_vec(), exp_vec());
  endtask

  // Called at a negedge; returns at the next negedge with reset released.
  task automatic do_reset();
    rst_n = 0; a_req = 0; b_req = 0; clear_start = 0;
    #1 chk("rst_now", dut_vec(), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drive_random();
    if (!a_req || a_ack) begin
      a_req  = ($urandom_range(0, 3) != 0);
      a_addr = AW'($urandom);
      a_data = DW'($urandom);
    end
    if (!b_req || b_ack) begin
      b_req  = ($urandom_range(0, 3) != 0);
      b_addr = AW'($urandom);
      b_data = DW'($urandom);
    end
    clear_start = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    rst_n = 0; a_req = 0; b_req = 0; clear_start = 0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    model_reset();
    @(negedge clk);
    chk("reset", dut_vec(), 32'd0);
    rst_n = 1;

    // Single requester
    a_req = 1; a_addr = 6'd5; a_data = 8'h41;
    cycle();
    chk("t1_we", 32'(ram_we), 32'd1);
    chk("t1_addr", 32'(ram_addr), 32'd5);
    chk("t1_d", 32'(ram_d), 32'h41);
    chk("t1_aack", 32'(a_ack), 32'd1);
    chk("t1_back", 32'(b_ack), 32'd0);
    a_req = 0;
    cycle();
    chk("t1_once", 32'(a_ack), 32'd0);

    // Simultaneous requests after reset: A first
    do_reset();
    a_req = 1; a_addr = 6'd1; a_data = 8'h11;
    b_req = 1; b_addr = 6'd2; b_data = 8'h22;
    cycle();
    chk("t2_a_ack", 32'(a_ack), 32'd1);
    chk("t2_a_addr", 32'(ram_addr), 32'd1);
    a_req = 0;
    cycle();
    chk("t2_b_ack", 32'(b_ack), 32'd1);
    chk("t2_b_d", 32'(ram_d), 32'h22);
    chk("t2_a_quiet", 32'(a_ack), 32'd0);
    b_req = 0;
    cycle();
    chk("t2_idle", 32'(ram_we), 32'd0);

    // Continuous requests alternate
    do_reset();
    a_req = 1; a_addr = 6'd0;  a_data = 8'hA0;
    b_req = 1; b_addr = 6'd32; b_data = 8'hB0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("alt_a", 32'(a_ack), 32'(i % 2 == 0));
      chk("alt_b", 32'(b_ack), 32'(i % 2 == 1));
      if (a_ack) begin a_addr = a_addr + 1'b1; a_data = a_data + 1'b1; end
      if (b_ack) begin b_addr = b_addr + 1'b1; b_data = b_data + 1'b1; end
    end
    a_req = 0; b_req = 0;
    cycle();

`ifdef LCD_ARB_CLEAR_EN
    // Full clear with a request and a second clear_start arriving mid-way
    do_reset();
    clear_start = 1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      clear_start = 0;
      chk("clr_addr", 32'(ram_addr), 32'(i));
      chk("clr_d", 32'(ram_d), 32'h20);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_done", 32'(clear_done), 32'(i == DEPTH - 1));
      chk("clr_no_ack", 32'(a_ack), 32'd0);
      if (i == 10) begin a_req = 1; a_addr = 6'd7; a_data = 8'h55; end
      if (i == 20) clear_start = 1;
    end
    cycle();
    chk("clr_end_busy", 32'(busy), 32'd0);
    chk("clr_end_ack", 32'(a_ack), 32'd1);
    chk("clr_end_addr", 32'(ram_addr), 32'd7);
    a_req = 0;
    cycle();

    // Reset mid-clear
    do_reset();
    clear_start = 1;
    for (int i = 0; i <= 30; i++) begin
      cycle();
      clear_start = 0;
    end
    chk("mid_addr30", 32'(ram_addr), 32'd30);
    do_reset();
    a_req = 1; a_addr = 6'd9;  a_data = 8'h99;
    b_req = 1; b_addr = 6'd10; b_data = 8'hAA;
    cycle();
    chk("post_rst_a", 32'(a_ack), 32'd1);
    chk("post_rst_done", 32'(clear_done), 32'd0);
    a_req = 0;
    cycle();
    b_req = 0;
    cycle();
`else
    // Without the sequencer clear_start is ignored
    do_reset();
    clear_start = 1; a_req = 1; a_addr = 6'd3; a_data = 8'h33;
    cycle();
    chk("noclr_busy", 32'(busy), 32'd0);
    chk("noclr_ack", 32'(a_ack), 32'd1);
    clear_start = 0; a_req = 0;
    cycle();
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
